// File: rtl/reg_bus_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_mem_ctrl
// Description : Memory-side responder for the register bus. Queues read/write
//               pulses, runs each in order against a synchronous memory port
//               and broadcasts the completion for two clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_oe,
    input  logic              read_q,
    input  logic              write_q,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              read_dn,
    output logic              write_dn,
    output logic              is_bus_busy,
    output logic              q_full,
    output logic              err_ovf,
    output logic              err_tmo,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE0 = 3'd3,
        S_DONE1 = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_fifo_wr   [QDEPTH];
    logic [ADDR_W-1:0] r_fifo_addr [QDEPTH];
    logic [DATA_W-1:0] r_fifo_data [QDEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_cur_wr;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [DATA_W-1:0] r_cur_data;
    logic [TW-1:0]     r_tmo;

    logic              w_req_wr;
    logic              w_req_rd;
    logic [CW-1:0]     w_free;
    logic              w_acc_wr;
    logic              w_acc_rd;
    logic              w_drop;
    logic              w_pop;
    logic [PW-1:0]     w_rd_slot;

    assign w_req_wr  = clk_oe & write_q;
    assign w_req_rd  = clk_oe & read_q;
    assign w_free    = CW'(QDEPTH) - r_count;
    // Write has priority for the free slots; the read needs one more beyond it.
    assign w_acc_wr  = w_req_wr && (w_free != '0);
    assign w_acc_rd  = w_req_rd && (w_free > (w_acc_wr ? CW'(1) : CW'(0)));
    assign w_drop    = (w_req_wr & ~w_acc_wr) | (w_req_rd & ~w_acc_rd);
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_rd_slot = r_wptr + PW'(w_acc_wr);
    assign q_full    = (r_count == CW'(QDEPTH));

    always_ff @(posedge clk) begin
        if (w_acc_wr) begin
            r_fifo_wr[r_wptr]   <= 1'b1;
            r_fifo_addr[r_wptr] <= addr_in;
            r_fifo_data[r_wptr] <= data_in;
        end
        if (w_acc_rd) begin
            r_fifo_wr[w_rd_slot]   <= 1'b0;
            r_fifo_addr[w_rd_slot] <= addr_in;
            r_fifo_data[w_rd_slot] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            err_ovf <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_acc_wr) + PW'(w_acc_rd);
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_acc_wr) + CW'(w_acc_rd) - CW'(w_pop);
            if (w_drop) begin
                err_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_wr    <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_data  <= '0;
            r_tmo       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            addr_out    <= '0;
            data_out    <= '0;
            read_dn     <= 1'b0;
            write_dn    <= 1'b0;
            is_bus_busy <= 1'b0;
            err_tmo     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    is_bus_busy <= 1'b0;
                    read_dn     <= 1'b0;
                    write_dn    <= 1'b0;
                    addr_out    <= '0;
                    data_out    <= '0;
                    if (w_pop) begin
                        r_cur_wr   <= r_fifo_wr[r_rptr];
                        r_cur_addr <= r_fifo_addr[r_rptr];
                        r_cur_data <= r_fifo_data[r_rptr];
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_addr  <= r_cur_addr;
                    mem_wdata <= r_cur_data;
                    mem_rd    <= ~r_cur_wr;
                    mem_wr    <= r_cur_wr;
                    r_tmo     <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        if (!r_cur_wr) begin
                            r_cur_data <= mem_rdata;
                        end
                        r_state <= S_DONE0;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        // Abort: the echo carries zero data so managers can still release.
                        mem_rd     <= 1'b0;
                        mem_wr     <= 1'b0;
                        err_tmo    <= 1'b1;
                        r_cur_data <= '0;
                        r_state    <= S_DONE0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_DONE0: begin
                    is_bus_busy <= 1'b1;
                    read_dn     <= ~r_cur_wr;
                    write_dn    <= r_cur_wr;
                    addr_out    <= r_cur_addr;
                    data_out    <= r_cur_data;
                    r_state     <= S_DONE1;
                end
                S_DONE1: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
